// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for the pipelined core. It owns the destination-tag pipeline
// (E/M/W) rather than taking it from the controller, and from those tags it
// produces forwarding selects, load-use and PC-write stalls/flushes, and
// multi-cycle data-memory stalls.
//
// Parameters
//   AW       register-address width (2**AW architectural registers)
//   PC_REG   index of the PC register; never forwarded, never a load-use hazard
//   MEM_LAT  data-memory latency in cycles (>=1); 1 = single-cycle M stage
//   CW       width of the optional performance counters
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   ra1d, ra2d, wa3d      D-stage source/destination register addresses
//   regwrited             D-stage instruction writes a register
//   memtoregd             D-stage instruction is a load
//   pcsrcd                D-stage instruction writes PC
//   branchtakene          branch resolved taken in E
//   forwardae, forwardbe  operand select: 00 regfile, 10 from M, 01 from W
//   stallf, stalld        hold fetch PC / hold F/D register
//   memstall              hold D/E and E/M registers; W receives a bubble
//   flushd, flushe        clear F/D / clear D/E register
//   wa3m, wa3w            M/W destination tags
//   regwritew, pcsrcw     W-stage register write enable / PC write
//   stall_cnt, flush_cnt  stall and flush cycle counters (saturating)
//
// Build option
//   HAZARD_PERF_CNT_EN    when defined, stall_cnt/flush_cnt count cycles with
//                         stallf=1 and with flushd|flushe=1 respectively.
//                         When undefined both are tied to 0 and no counter
//                         flops exist.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int AW      = 4,
    parameter int PC_REG  = 15,
    parameter int MEM_LAT = 1,
    parameter int CW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra1d,
    input  logic [AW-1:0] ra2d,
    input  logic [AW-1:0] wa3d,
    input  logic          regwrited,
    input  logic          memtoregd,
    input  logic          pcsrcd,
    input  logic          branchtakene,
    output logic [1:0]    forwardae,
    output logic [1:0]    forwardbe,
    output logic          stallf,
    output logic          stalld,
    output logic          memstall,
    output logic          flushd,
    output logic          flushe,
    output logic [AW-1:0] wa3m,
    output logic [AW-1:0] wa3w,
    output logic          regwritew,
    output logic          pcsrcw,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

    // Counter wide enough to hold MEM_LAT-1; a single bit when unused.
    localparam int CNTW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    // -----------------------------------------------------------------------
    // Tag pipeline state
    // -----------------------------------------------------------------------
    // The load flag is only needed while the instruction sits in E: it
    // drives the load-use check and starts the memory-latency counter as
    // the load moves into M. Later stages therefore do not carry it.
    logic [AW-1:0] ra1e, ra2e, wa3e;
    logic          regwritee, memtorege, pcsrce;
    logic          regwritem, pcsrcm;

    logic [CNTW-1:0] mem_cnt;

    logic ldrstall;
    logic pcwrpend;

    // -----------------------------------------------------------------------
    // Data-memory latency counter
    // -----------------------------------------------------------------------
    generate
        if (MEM_LAT > 1) begin : g_mem_cnt
            // A load moves from E into M on any non-stalled cycle (normal
            // advance or flushe, since only E itself is cleared by flushe),
            // so the counter starts whenever it is idle and E holds a load.
            // NOTE: state updates use non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_cnt <= '0;
                end else if (mem_cnt != '0) begin
                    mem_cnt <= mem_cnt - CNTW'(1);
                end else if (memtorege) begin
                    mem_cnt <= CNTW'(MEM_LAT - 1);
                end
            end
        end else begin : g_no_mem_cnt
            assign mem_cnt = '0;
        end
    endgenerate

    assign memstall = (mem_cnt != '0);

    // -----------------------------------------------------------------------
    // Stage advance: memstall > flushe > normal
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra1e      <= '0;
            ra2e      <= '0;
            wa3e      <= '0;
            regwritee <= 1'b0;
            memtorege <= 1'b0;
            pcsrce    <= 1'b0;
            wa3m      <= '0;
            regwritem <= 1'b0;
            pcsrcm    <= 1'b0;
            wa3w      <= '0;
            regwritew <= 1'b0;
            pcsrcw    <= 1'b0;
        end else if (memstall) begin
            // E and M hold while the memory access completes; W gets a bubble
            // so the instruction ahead of the load is not written twice.
            wa3w      <= '0;
            regwritew <= 1'b0;
            pcsrcw    <= 1'b0;
        end else begin
            wa3w      <= wa3m;
            regwritew <= regwritem;
            pcsrcw    <= pcsrcm;
            wa3m      <= wa3e;
            regwritem <= regwritee;
            pcsrcm    <= pcsrce;
            if (flushe) begin
                ra1e      <= '0;
                ra2e      <= '0;
                wa3e      <= '0;
                regwritee <= 1'b0;
                memtorege <= 1'b0;
                pcsrce    <= 1'b0;
            end else begin
                ra1e      <= ra1d;
                ra2e      <= ra2d;
                wa3e      <= wa3d;
                regwritee <= regwrited;
                memtorege <= memtoregd;
                pcsrce    <= pcsrcd;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding: M has the newer value, so it wins over W. The PC register
    // is read through its own path and is never forwarded.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        forwardae = 2'b00;
        forwardbe = 2'b00;
        if (regwritem && (wa3m == ra1e) && (ra1e != PC_ADDR)) begin
            forwardae = 2'b10;
        end else if (regwritew && (wa3w == ra1e) && (ra1e != PC_ADDR)) begin
            forwardae = 2'b01;
        end
        if (regwritem && (wa3m == ra2e) && (ra2e != PC_ADDR)) begin
            forwardbe = 2'b10;
        end else if (regwritew && (wa3w == ra2e) && (ra2e != PC_ADDR)) begin
            forwardbe = 2'b01;
        end
    end

    // -----------------------------------------------------------------------
    // Stalls and flushes
    // -----------------------------------------------------------------------
    assign ldrstall = memtorege && regwritee && (wa3e != PC_ADDR) &&
                      ((wa3e == ra1d) || (wa3e == ra2d));

    // Any PC write still in flight before W makes the fetched stream stale.
    assign pcwrpend = pcsrcd | pcsrce | pcsrcm;

    assign stallf = ldrstall | pcwrpend | memstall;
    assign stalld = ldrstall | memstall;

    // Flushes are suppressed during memstall; the controller keeps
    // branchtakene asserted, so the flush lands on the first free cycle.
    assign flushd = (pcwrpend | pcsrcw | branchtakene) & ~memstall;
    assign flushe = (ldrstall | branchtakene) & ~memstall;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CW-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallf && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
            if ((flushd || flushe) && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CW'(1);
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard. Two instances share the stimulus:
// u_dut1 (MEM_LAT=1, CW=4) covers forwarding, load-use, PC write, PC_REG
// exclusion and counter saturation; u_dut2 (MEM_LAT=3) covers memory stalls
// and asynchronous reset during a stall. Expected values are queued as each
// cycle's inputs are driven and compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int AW = 4;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Observable signal ids; dut2 ids are dut1 ids + 16.
    localparam int S_FA = 0, S_FB = 1, S_SF = 2, S_SD = 3, S_MS = 4,
                   S_FD = 5, S_FE = 6, S_WA3M = 7, S_WA3W = 8, S_RWW = 9,
                   S_PCW = 10, S_SCNT = 11, S_FCNT = 12;
    localparam int D2 = 16;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ra1d, ra2d, wa3d;
    logic          regwrited, memtoregd, pcsrcd, branchtakene;

    logic [1:0]    fa1, fb1, fa2, fb2;
    logic          sf1, sd1, ms1, fd1, fe1, rww1, pcw1;
    logic          sf2, sd2, ms2, fd2, fe2, rww2, pcw2;
    logic [AW-1:0] wa3m1, wa3w1, wa3m2, wa3w2;
    logic [3:0]    scnt1, fcnt1;
    logic [31:0]   scnt2, fcnt2;

    always #5 clk = ~clk;

    hazard_scoreboard #(.AW(AW), .PC_REG(15), .MEM_LAT(1), .CW(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .ra1d(ra1d), .ra2d(ra2d), .wa3d(wa3d),
        .regwrited(regwrited), .memtoregd(memtoregd), .pcsrcd(pcsrcd),
        .branchtakene(branchtakene),
        .forwardae(fa1), .forwardbe(fb1),
        .stallf(sf1), .stalld(sd1), .memstall(ms1),
        .flushd(fd1), .flushe(fe1),
        .wa3m(wa3m1), .wa3w(wa3w1), .regwritew(rww1), .pcsrcw(pcw1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    hazard_scoreboard #(.AW(AW), .PC_REG(15), .MEM_LAT(3), .CW(32)) u_dut2 (
        .clk(clk), .reset(reset),
        .ra1d(ra1d), .ra2d(ra2d), .wa3d(wa3d),
        .regwrited(regwrited), .memtoregd(memtoregd), .pcsrcd(pcsrcd),
        .branchtakene(branchtakene),
        .forwardae(fa2), .forwardbe(fb2),
        .stallf(sf2), .stalld(sd2), .memstall(ms2),
        .flushd(fd2), .flushe(fe2),
        .wa3m(wa3m2), .wa3w(wa3w2), .regwritew(rww2), .pcsrcw(pcw2),
        .stall_cnt(scnt2), .flush_cnt(fcnt2)
    );

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            S_FA:        return 32'(fa1);
            S_FB:        return 32'(fb1);
            S_SF:        return 32'(sf1);
            S_SD:        return 32'(sd1);
            S_MS:        return 32'(ms1);
            S_FD:        return 32'(fd1);
            S_FE:        return 32'(fe1);
            S_WA3M:      return 32'(wa3m1);
            S_WA3W:      return 32'(wa3w1);
            S_RWW:       return 32'(rww1);
            S_PCW:       return 32'(pcw1);
            S_SCNT:      return 32'(scnt1);
            S_FCNT:      return 32'(fcnt1);
            D2 + S_FA:   return 32'(fa2);
            D2 + S_FB:   return 32'(fb2);
            D2 + S_SF:   return 32'(sf2);
            D2 + S_SD:   return 32'(sd2);
            D2 + S_MS:   return 32'(ms2);
            D2 + S_FD:   return 32'(fd2);
            D2 + S_FE:   return 32'(fe2);
            D2 + S_WA3M: return 32'(wa3m2);
            D2 + S_WA3W: return 32'(wa3w2);
            D2 + S_RWW:  return 32'(rww2);
            D2 + S_PCW:  return 32'(pcw2);
            D2 + S_SCNT: return scnt2;
            D2 + S_FCNT: return fcnt2;
            default:     return 32'hdead_beef;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic push_all_zero(input string tag, input int base);
        for (int i = 0; i <= S_FCNT; i++) begin
            push_exp(tag, base + i, 32'd0);
        end
    endtask

    task automatic flush_q();
        exp_t        e;
        logic [31:0] o;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.sig);
            checks++;
            assert (o === e.val) else begin
                failures++;
                $error("FAIL %s sig=%0d: observed=%0h expected=%0h", e.tag, e.sig, o, e.val);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        flush_q();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [AW-1:0] w, input logic rw, input logic mtr,
                         input logic pcs, input logic bt);
        ra1d         = r1;
        ra2d         = r2;
        wa3d         = w;
        regwrited    = rw;
        memtoregd    = mtr;
        pcsrcd       = pcs;
        branchtakene = bt;
    endtask

    task automatic nop();
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        next_cycle();
        nop();
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        nop();

        // ---------------- reset state ----------------
        push_all_zero("reset_dut1", 0);
        push_all_zero("reset_dut2", D2);
        sample();
        next_cycle();
        reset = 1'b0;

        // ---------------- 1) ALU dependency ----------------
        drive(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);      // writer r3
        push_exp("alu_wr_nostall", S_SF, 32'd0);
        sample();
        next_cycle();
        drive(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);      // reader ra1=3
        push_exp("alu_rd_fa_not_yet", S_FA, 32'd0);
        sample();
        next_cycle();
        nop();
        push_exp("alu_fwd_m", S_FA, 32'd2);
        push_exp("alu_wa3m", S_WA3M, 32'd3);
        push_exp("alu_fb_none", S_FB, 32'd0);
        sample();
        repeat (3) begin next_cycle(); nop(); end
        next_cycle();
        drive(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);      // writer r3
        next_cycle();
        nop();                                                 // gap
        next_cycle();
        drive(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);      // reader ra1=3
        next_cycle();
        drive(4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);      // writer r4
        push_exp("alu_fwd_w", S_FA, 32'd1);
        push_exp("alu_wa3w", S_WA3W, 32'd3);
        push_exp("alu_rww", S_RWW, 32'd1);
        sample();
        next_cycle();
        drive(4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);      // writer r4 again
        next_cycle();
        drive(4'd0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);      // reader ra2=4
        next_cycle();
        nop();
        push_exp("alu_m_wins", S_FB, 32'd2);
        push_exp("alu_m_wins_fa", S_FA, 32'd0);
        sample();

        // ---------------- 2) load-use ----------------
        repeat (3) begin next_cycle(); nop(); end
        next_cycle();
        drive(4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);      // LDR r2
        push_exp("ldr_issue_sf", S_SF, 32'd0);
        sample();
        next_cycle();
        drive(4'd0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);      // reader ra2=2
        push_exp("ldr_use_sf", S_SF, 32'd1);
        push_exp("ldr_use_sd", S_SD, 32'd1);
        push_exp("ldr_use_fe", S_FE, 32'd1);
        push_exp("ldr_use_fd", S_FD, 32'd0);
        sample();
        next_cycle();                                          // D held
        push_exp("ldr_bubble_sf", S_SF, 32'd0);
        push_exp("ldr_bubble_sd", S_SD, 32'd0);
        push_exp("ldr_bubble_fe", S_FE, 32'd0);
        sample();
        next_cycle();
        nop();
        push_exp("ldr_fwd_w", S_FB, 32'd1);
        push_exp("ldr_wa3w", S_WA3W, 32'd2);
        sample();

        // ---------------- 3) PC write ----------------
        repeat (3) begin next_cycle(); nop(); end
        next_cycle();
        drive(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);     // PC write in D
        push_exp("pc_d_sf", S_SF, 32'd1);
        push_exp("pc_d_fd", S_FD, 32'd1);
        push_exp("pc_d_sd", S_SD, 32'd0);
        sample();
        next_cycle();
        nop();
        push_exp("pc_e_sf", S_SF, 32'd1);
        push_exp("pc_e_fd", S_FD, 32'd1);
        sample();
        next_cycle();
        push_exp("pc_m_sf", S_SF, 32'd1);
        push_exp("pc_m_fd", S_FD, 32'd1);
        push_exp("pc_m_pcw", S_PCW, 32'd0);
        sample();
        next_cycle();
        push_exp("pc_w_sf", S_SF, 32'd0);
        push_exp("pc_w_fd", S_FD, 32'd1);
        push_exp("pc_w_pcw", S_PCW, 32'd1);
        push_exp("pc_w_wa3w", S_WA3W, 32'd15);
        sample();
        next_cycle();
        push_exp("pc_done_fd", S_FD, 32'd0);
        push_exp("pc_done_pcw", S_PCW, 32'd0);
        sample();

        // ---------------- 5a) PC_REG excluded ----------------
        repeat (2) begin next_cycle(); nop(); end
        next_cycle();
        drive(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);     // write r15 (no pcsrc)
        next_cycle();
        drive(4'd15, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);     // reader ra1=15
        next_cycle();
        drive(4'd0, 4'd0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0);     // LDR r15
        push_exp("pcreg_nofwd", S_FA, 32'd0);
        push_exp("pcreg_wa3m", S_WA3M, 32'd15);
        sample();
        next_cycle();
        drive(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);    // reader r15 after LDR r15
        push_exp("pcreg_noldr_sf", S_SF, 32'd0);
        push_exp("pcreg_noldr_fe", S_FE, 32'd0);
        sample();

        // ---------------- 4) MEM_LAT=3 + held branch ----------------
        pulse_reset();
        next_cycle();
        drive(4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);      // LDR r2
        push_exp("ml_issue_ms", D2 + S_MS, 32'd0);
        sample();
        next_cycle();
        nop();
        push_exp("ml_e_ms", D2 + S_MS, 32'd0);
        sample();
        next_cycle();
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);      // branch taken
        push_exp("ml_s1_ms", D2 + S_MS, 32'd1);
        push_exp("ml_s1_sf", D2 + S_SF, 32'd1);
        push_exp("ml_s1_sd", D2 + S_SD, 32'd1);
        push_exp("ml_s1_fd", D2 + S_FD, 32'd0);
        push_exp("ml_s1_fe", D2 + S_FE, 32'd0);
        push_exp("ml_s1_rww", D2 + S_RWW, 32'd0);
        push_exp("ml_s1_wa3m", D2 + S_WA3M, 32'd2);
        sample();
        next_cycle();
        push_exp("ml_s2_ms", D2 + S_MS, 32'd1);
        push_exp("ml_s2_fd", D2 + S_FD, 32'd0);
        push_exp("ml_s2_fe", D2 + S_FE, 32'd0);
        push_exp("ml_s2_rww", D2 + S_RWW, 32'd0);
        sample();
        next_cycle();
        push_exp("ml_end_ms", D2 + S_MS, 32'd0);
        push_exp("ml_end_fd", D2 + S_FD, 32'd1);
        push_exp("ml_end_fe", D2 + S_FE, 32'd1);
        push_exp("ml_end_rww", D2 + S_RWW, 32'd0);
        push_exp("ml_end_wa3m", D2 + S_WA3M, 32'd2);
        sample();
        next_cycle();
        nop();
        push_exp("ml_w_rww", D2 + S_RWW, 32'd1);
        push_exp("ml_w_wa3w", D2 + S_WA3W, 32'd2);
        push_exp("ml_w_ms", D2 + S_MS, 32'd0);
        push_exp("ml_w_fe", D2 + S_FE, 32'd0);
        sample();

        // ---------------- 5b) async reset mid-memstall ----------------
        repeat (2) begin next_cycle(); nop(); end
        next_cycle();
        drive(4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);      // LDR r5
        next_cycle();
        nop();
        next_cycle();
        push_exp("rst_pre_ms", D2 + S_MS, 32'd1);
        sample();
        #1;
        reset = 1'b1;
        #1;
        push_all_zero("rst_mid", D2);
        flush_q();
        #1;
        reset = 1'b0;
        next_cycle();
        push_exp("rst_after_ms", D2 + S_MS, 32'd0);
        push_exp("rst_after_rww", D2 + S_RWW, 32'd0);
        push_exp("rst_after_wa3m", D2 + S_WA3M, 32'd0);
        push_exp("rst_after_fd", D2 + S_FD, 32'd0);
        sample();

        // ---------------- 6) perf counters (CW=4) ----------------
        pulse_reset();
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);  // keeps stallf high
            if (i == 1) begin
                push_exp("perf_start", S_SCNT, 32'd0);
                sample();
            end else if (i == 15) begin
                push_exp("perf_14", S_SCNT, PERF ? 32'd14 : 32'd0);
                push_exp("perf_fl_14", S_FCNT, PERF ? 32'd14 : 32'd0);
                sample();
            end
        end
        next_cycle();
        nop();
        push_exp("perf_sat", S_SCNT, PERF ? 32'd15 : 32'd0);
        push_exp("perf_fl_sat", S_FCNT, PERF ? 32'd15 : 32'd0);
        sample();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
